// File: rtl/fifo_pkg.sv
// Shared sizing defaults and types for the single-clock FIFO.
package fifo_pkg;

    localparam int unsigned DEF_DATASIZE = 8;
    localparam int unsigned DEF_ADDRSIZE = 9;

    // Pointer at default sizing: one wrap bit above the address bits.
    typedef logic [DEF_ADDRSIZE:0] ptr_t;

    typedef enum logic {
        EMPTY = 1'b0,
        VALID = 1'b1
    } pf_state_e;

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Handshake/data bundle between a producer/consumer (master) and the FIFO (slave).
interface sync_fifo_ctrl_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATASIZE = DEF_DATASIZE,
    parameter int unsigned ADDRSIZE = DEF_ADDRSIZE
);

    logic                flush;
    logic                w_inc;
    logic [DATASIZE-1:0] wdata;
    logic                r_inc;
    logic [DATASIZE-1:0] rdata;
    logic                wfull;
    logic                rempty;
    logic                almost_full;
    logic                almost_empty;
    logic [ADDRSIZE:0]   count;
    logic                overflow;
    logic                underflow;

    modport master (
        output flush, w_inc, wdata, r_inc,
        input  rdata, wfull, rempty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, w_inc, wdata, r_inc,
        output rdata, wfull, rempty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered read with read enable.
module sync_fifo_mem #(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned ADDRSIZE = 9
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic [ADDRSIZE-1:0] waddr_i,
    input  logic [DATASIZE-1:0] wdata_i,
    input  logic                re_i,
    input  logic [ADDRSIZE-1:0] raddr_i,
    output logic [DATASIZE-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDRSIZE;

    logic [DATASIZE-1:0] mem_q [DEPTH];
    logic [DATASIZE-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset; the array itself carries no reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, flags, occupancy, sticky errors, flush,
// and optional first-word-fall-through prefetch in front of sync_fifo_mem.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATASIZE   = DEF_DATASIZE,
    parameter int unsigned ADDRSIZE   = DEF_ADDRSIZE,
    parameter int unsigned AFULL_TH   = (1 << ADDRSIZE) - 4,
    parameter int unsigned AEMPTY_TH  = 4,
    parameter int unsigned SHOW_AHEAD = 0
) (
    input  logic            clk,
    input  logic            rst,
    sync_fifo_ctrl_if.slave bus
);

    typedef logic [ADDRSIZE:0] fptr_t;

    localparam int unsigned DEPTH    = 1 << ADDRSIZE;
    localparam fptr_t       DEPTH_C  = fptr_t'(DEPTH);
    localparam fptr_t       AFULL_C  = fptr_t'(AFULL_TH);
    localparam fptr_t       AEMPTY_C = fptr_t'(AEMPTY_TH);
    localparam fptr_t       PTR_ONE  = fptr_t'(1);

    fptr_t               wptr_q, wptr_d;
    fptr_t               rptr_q, rptr_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    fptr_t               mem_cnt;
    fptr_t               cnt;
    logic                mem_empty;
    logic                mem_full;
    logic                out_valid;
    logic                wfull;
    logic                rempty;
    logic                wr_acc;
    logic                rd_acc;
    logic                mem_re;
    logic [DATASIZE-1:0] mem_rdata;

    // Everything below is derived from registered state only.
    assign mem_cnt   = wptr_q - rptr_q;
    assign mem_empty = (wptr_q == rptr_q);
    assign mem_full  = (wptr_q[ADDRSIZE] != rptr_q[ADDRSIZE]) &&
                       (wptr_q[ADDRSIZE-1:0] == rptr_q[ADDRSIZE-1:0]);
    assign cnt       = mem_cnt + fptr_t'(out_valid);

    assign wr_acc = bus.w_inc && !wfull  && !bus.flush;
    assign rd_acc = bus.r_inc && !rempty && !bus.flush;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        if (bus.flush) begin
            wptr_d = '0;
            rptr_d = '0;
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (mem_re) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            if (bus.w_inc && wfull) begin
                ovf_d = 1'b1;
            end
            if (bus.r_inc && rempty) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    generate
        if (SHOW_AHEAD != 0) begin : g_show_ahead
            pf_state_e state_q, state_d;
            logic      fetch;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= EMPTY;
                end else begin
                    state_q <= state_d;
                end
            end

            // The RAM output register doubles as the head-word register.
            always_comb begin
                state_d = state_q;
                fetch   = 1'b0;
                if (bus.flush) begin
                    state_d = EMPTY;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (!mem_empty) begin
                                fetch   = 1'b1;
                                state_d = VALID;
                            end
                        end
                        VALID: begin
                            if (rd_acc) begin
                                if (!mem_empty) begin
                                    fetch = 1'b1;
                                end else begin
                                    state_d = EMPTY;
                                end
                            end
                        end
                        default: state_d = EMPTY;
                    endcase
                end
            end

            assign out_valid = (state_q == VALID);
            assign mem_re    = fetch;
            assign wfull     = (cnt == DEPTH_C);
            assign rempty    = !out_valid;
        end else begin : g_standard
            assign out_valid = 1'b0;
            assign mem_re    = rd_acc;
            assign wfull     = mem_full;
            assign rempty    = mem_empty;
        end
    endgenerate

    sync_fifo_mem #(
        .DATASIZE(DATASIZE),
        .ADDRSIZE(ADDRSIZE)
    ) u_mem (
        .clk_i  (clk),
        .rst_i  (rst),
        .we_i   (wr_acc),
        .waddr_i(wptr_q[ADDRSIZE-1:0]),
        .wdata_i(bus.wdata),
        .re_i   (mem_re),
        .raddr_i(rptr_q[ADDRSIZE-1:0]),
        .rdata_o(mem_rdata)
    );

    assign bus.rdata        = mem_rdata;
    assign bus.wfull        = wfull;
    assign bus.rempty       = rempty;
    assign bus.almost_full  = (cnt >= AFULL_C);
    assign bus.almost_empty = (cnt <= AEMPTY_C);
    assign bus.count        = cnt;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed scoreboard bench for sync_fifo_ctrl in standard and show-ahead modes.
module tb_sync_fifo_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF_TH = 6;
    localparam int unsigned AE_TH = 1;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          w_inc;
    logic          r_inc;
    logic [DW-1:0] wdata;
    bit            mode;

    int unsigned n_chk;
    int unsigned n_fail;

    // Scoreboard: every word in the FIFO, oldest first, plus modelled flags.
    logic [DW-1:0] sb[$];
    bit            m_ov;
    bit            m_ovf;
    bit            m_unf;
    logic [DW-1:0] m_rdata;

    sync_fifo_ctrl_if #(.DATASIZE(DW), .ADDRSIZE(AW)) if0 ();
    sync_fifo_ctrl_if #(.DATASIZE(DW), .ADDRSIZE(AW)) if1 ();

    assign if0.flush = flush;
    assign if0.w_inc = w_inc;
    assign if0.wdata = wdata;
    assign if0.r_inc = r_inc;
    assign if1.flush = flush;
    assign if1.w_inc = w_inc;
    assign if1.wdata = wdata;
    assign if1.r_inc = r_inc;

    sync_fifo_ctrl #(
        .DATASIZE(DW), .ADDRSIZE(AW), .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH), .SHOW_AHEAD(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .bus(if0)
    );

    sync_fifo_ctrl #(
        .DATASIZE(DW), .ADDRSIZE(AW), .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH), .SHOW_AHEAD(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );

    logic [DW-1:0] o_rdata;
    logic [AW:0]   o_count;
    logic          o_wfull, o_rempty, o_af, o_ae, o_ovf, o_unf;

    assign o_rdata  = mode ? if1.rdata        : if0.rdata;
    assign o_count  = mode ? if1.count        : if0.count;
    assign o_wfull  = mode ? if1.wfull        : if0.wfull;
    assign o_rempty = mode ? if1.rempty       : if0.rempty;
    assign o_af     = mode ? if1.almost_full  : if0.almost_full;
    assign o_ae     = mode ? if1.almost_empty : if0.almost_empty;
    assign o_ovf    = mode ? if1.overflow     : if0.overflow;
    assign o_unf    = mode ? if1.underflow    : if0.underflow;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (mode %0d): observed 0x%0h expected 0x%0h", tag, mode, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int unsigned tot;
        tot = sb.size();
        chk({tag, ".count"},  32'(o_count),  tot);
        chk({tag, ".wfull"},  32'(o_wfull),  32'(tot == DEPTH));
        chk({tag, ".rempty"}, 32'(o_rempty), 32'(mode ? !m_ov : (tot == 0)));
        chk({tag, ".afull"},  32'(o_af),     32'(tot >= AF_TH));
        chk({tag, ".aempty"}, 32'(o_ae),     32'(tot <= AE_TH));
        chk({tag, ".ovf"},    32'(o_ovf),    32'(m_ovf));
        chk({tag, ".unf"},    32'(o_unf),    32'(m_unf));
        chk({tag, ".rdata"},  32'(o_rdata),  32'(m_rdata));
    endtask

    task automatic model_reset();
        sb.delete();
        m_ov    = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_rdata = '0;
    endtask

    // One clock: drive, take the edge, advance the model, compare everything.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
        int unsigned   tot;
        int unsigned   memw;
        bit            full_p, empty_p, wacc, racc;
        logic [DW-1:0] popped;
        w_inc = w;
        wdata = d;
        r_inc = r;
        flush = f;
        @(posedge clk);
        #1;
        tot     = sb.size();
        memw    = tot - (m_ov ? 1 : 0);
        full_p  = (tot == DEPTH);
        empty_p = mode ? !m_ov : (tot == 0);
        if (f) begin
            sb.delete();
            m_ov  = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            wacc = w && !full_p;
            racc = r && !empty_p;
            if (w && full_p) m_ovf = 1'b1;
            if (r && empty_p) m_unf = 1'b1;
            if (racc) begin
                popped = sb.pop_front();
                if (!mode) m_rdata = popped;
            end
            if (mode && (!m_ov || racc)) m_ov = (memw > 0);
            if (wacc) sb.push_back(d);
            if (mode && m_ov) m_rdata = sb[0];
        end
        w_inc = 1'b0;
        r_inc = 1'b0;
        flush = 1'b0;
        check_all("step");
    endtask

    task automatic do_reset();
        flush = 1'b0;
        w_inc = 1'b0;
        r_inc = 1'b0;
        wdata = '0;
        rst   = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
    endtask

    task automatic run_suite(input bit m);
        mode = m;
        do_reset();
        step(1'b0, '0, 1'b0, 1'b0);

        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        chk("fill.count", 32'(o_count), 32'd8);
        chk("fill.wfull", 32'(o_wfull), 32'd1);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("fill.ovf", 32'(o_ovf), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            if (mode) chk("drain.head", 32'(o_rdata), 32'(i));
            step(1'b0, '0, 1'b1, 1'b0);
            if (!mode) chk("drain.data", 32'(o_rdata), 32'(i));
        end
        chk("drain.rempty", 32'(o_rempty), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("drain.unf", 32'(o_unf), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);

        step(1'b1, 8'h40, 1'b0, 1'b0);
        step(1'b1, 8'h41, 1'b0, 1'b0);
        for (int i = 2; i < 26; i++) step(1'b1, DW'(8'h40 + i), 1'b1, 1'b0);
        repeat (2) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("fullrw.count", 32'(o_count), 32'd7);
        chk("fullrw.ovf", 32'(o_ovf), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk("emptyrw.count", 32'(o_count), 32'd1);
        chk("emptyrw.unf", 32'(o_unf), 32'd1);

        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        if (mode) begin
            chk("lat.rempty_k", 32'(o_rempty), 32'd1);
            step(1'b0, '0, 1'b0, 1'b0);
            chk("lat.rempty_k1", 32'(o_rempty), 32'd0);
            chk("lat.rdata_k1", 32'(o_rdata), 32'hA5);
        end else begin
            chk("lat.rempty_k", 32'(o_rempty), 32'd0);
            step(1'b0, '0, 1'b1, 1'b0);
            chk("lat.rdata", 32'(o_rdata), 32'hA5);
        end

        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, DW'(8'h50 + i), 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);
        chk("preflush.count", 32'(o_count), 32'd5);
        chk("preflush.ovf", 32'(o_ovf), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("flush.count", 32'(o_count), 32'd0);
        chk("flush.rempty", 32'(o_rempty), 32'd1);
        chk("flush.ovf", 32'(o_ovf), 32'd0);

        for (int i = 0; i < 8; i++) step(1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        repeat (2) step(1'b0, '0, 1'b1, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("arst.rdata",  32'(o_rdata),  32'd0);
        chk("arst.count",  32'(o_count),  32'd0);
        chk("arst.wfull",  32'(o_wfull),  32'd0);
        chk("arst.rempty", 32'(o_rempty), 32'd1);
        chk("arst.afull",  32'(o_af),     32'd0);
        chk("arst.aempty", 32'(o_ae),     32'd1);
        chk("arst.ovf",    32'(o_ovf),    32'd0);
        chk("arst.unf",    32'(o_unf),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_all("post_rst");
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        flush  = 1'b0;
        w_inc  = 1'b0;
        r_inc  = 1'b0;
        wdata  = '0;
        mode   = 1'b0;
        model_reset();
        run_suite(1'b0);
        run_suite(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
